product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Consumer end of the multiplier stream: takes signed products with a valid strobe and sums every VEC_LEN accepted terms into one dot-product result.
- Emits the result with its own valid strobe and an early-warning strobe.
- Sits directly downstream of the registered multiplier in each dot-product lane.
- Its input handshake is the multiplier's output handshake: DP plus an outReady-style strobe.

Parameters:
- IN_WIDTH, 20, width of the signed product input.
- VEC_LEN, 16, terms per result; must be >= 1.
- ACC_WIDTH, IN_WIDTH+clog2(VEC_LEN) = 24, width of the accumulator and SUM.
- OUT_PIPE_DEPTH, 0, extra register stages after the SUM register; must be >= 0.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  clock enable; low freezes all state.
- clear  in  1  synchronous abort of the current vector.
- inReady  in  1  DP is valid this cycle.
- DP  in  IN_WIDTH  signed product term.
- termIndex  out  clog2(VEC_LEN) (min 1)  count of terms accepted in the current vector.
- SUM  out  ACC_WIDTH  signed accumulated result.
- outReady  out  1  SUM valid strobe.
- earlyOutReady  out  1  high one cycle before outReady.

Behaviour:
- Reset (reset=0, asynchronous): termIndex=0, accumulator=0, SUM=0, all pipe stages=0, outReady=0, earlyOutReady=0. Effect is immediate, mid-vector included; the partial sum is discarded.
- Cycle with enable=0: every register holds, outReady included. Strobes therefore last one enabled cycle.
- Priority in enabled cycles: clear > inReady.
- clear: termIndex<=0, accumulator<=0, pending output valids<=0. SUM data holds its value. A DP present in the same cycle is dropped.
- Accept: enable=1 and inReady=1 and clear=0.
  - DP is sign-extended to ACC_WIDTH.
  - termIndex==0: acc<=DP.
  - Otherwise: acc<=acc+DP.
  - termIndex increments.
- Final term (accept with termIndex==VEC_LEN-1):
  - SUM register <= acc+DP (acc=0 if VEC_LEN=1).
  - termIndex<=0 and the accumulator restarts.
  - The next vector may begin the following cycle with no bubble.
- Arithmetic is two's complement modulo 2^ACC_WIDTH. There is no saturation and no overflow flag. The default ACC_WIDTH cannot overflow.
- Latency: outReady rises 1+OUT_PIPE_DEPTH enabled cycles after the final-term accept.
  - Each pipe stage carries data plus valid.
  - Data stages load only when their valid input is set.
- earlyOutReady:
  - OUT_PIPE_DEPTH=0: combinational, equal to (final-term accept).
  - Otherwise: equal to the valid of the stage before the output.
- inReady gaps between terms of a vector are allowed and unbounded; the sum is unaffected.
- outReady is never asserted while termIndex advances, except through the pipeline for a previously completed vector. Outputs of consecutive vectors never merge.

Decomposition:
- Shared package holds:
  - the clog2 constant function;
  - default widths (IN_WIDTH=20, VEC_LEN=16);
  - the derived ACC_WIDTH expression, so lane generators and accumulators agree.
- One sub-module: valid_delay_line, a parameterised data+valid shift register with enable, clear and asynchronous active-low reset. It implements the OUT_PIPE_DEPTH stages, and a depth of 0 is a wire.

Test Plan:
1. VEC_LEN=4, OUT_PIPE_DEPTH=0, terms 1,2,3,4 on consecutive cycles: earlyOutReady=1 in the cycle of term 4; next cycle SUM=10 and outReady=1 for exactly one cycle.
2. VEC_LEN=16, DP=-524288 for 16 terms: SUM=-8388608 (0x800000). Then DP=524287 x16: SUM=8388592.
3. VEC_LEN=4, terms 5,_,6,_,_,7, then enable=0 for 3 cycles, then 8: SUM=26. termIndex holds at 3 during enable=0, and outReady stays 1 if enable drops right after it rises.
4. VEC_LEN=4, back-to-back terms 1..8 with no gaps: SUM=10 then SUM=26, outReady pulses exactly 4 cycles apart.
5. VEC_LEN=4:
   - Terms 9,9, then clear, then 7,7,7,7: SUM=28.
   - Terms 3,3, then reset low asynchronously between edges: termIndex, SUM and outReady read 0 before the next edge. After release, 1,1,1,1 gives SUM=4.
6. VEC_LEN=4, OUT_PIPE_DEPTH=2, terms 1,2,3,4: outReady and SUM=10 appear 3 cycles after term 4, and earlyOutReady is high exactly the cycle before.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared widths and helpers so lane generators and accumulators agree on sizing.
package product_accumulator_pkg;

    localparam int unsigned DEF_IN_WIDTH = 20;
    localparam int unsigned DEF_VEC_LEN  = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned vec_len);
        return in_w + clog2(vec_len);
    endfunction

    // A single-term vector still needs a one-bit index port.
    function automatic int unsigned idx_width(input int unsigned vec_len);
        return (clog2(vec_len) == 0) ? 1 : clog2(vec_len);
    endfunction

    localparam int unsigned DEF_ACC_WIDTH = acc_width(DEF_IN_WIDTH, DEF_VEC_LEN);

endpackage

// File: rtl/product_accumulator_delay.sv
// Data+valid shift register with clock enable, valid-only clear and async active-low reset.
// A depth of zero degenerates to a wire.
module valid_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             pre_valid
);

    if (DEPTH == 0) begin : g_wire
        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign pre_valid = in_valid;
    end else begin : g_regs
        logic [WIDTH-1:0] data_q [DEPTH];
        logic [DEPTH-1:0] vld_q;

        // Data stages only advance behind a set valid; clear kills valids but keeps data.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    data_q[i] <= '0;
                end
                vld_q <= '0;
            end else if (enable) begin
                if (clear) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= in_valid;
                    if (in_valid) begin
                        data_q[0] <= in_data;
                    end
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        if (vld_q[i-1]) begin
                            data_q[i] <= data_q[i-1];
                        end
                    end
                end
            end
        end

        assign out_data  = data_q[DEPTH-1];
        assign out_valid = vld_q[DEPTH-1];

        if (DEPTH == 1) begin : g_pre_in
            assign pre_valid = in_valid;
        end else begin : g_pre_reg
            assign pre_valid = vld_q[DEPTH-2];
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums every VEC_LEN accepted signed products into one result, with a valid strobe
// and an early-warning strobe one enabled cycle ahead of it.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = DEF_IN_WIDTH,
    parameter int unsigned VEC_LEN        = DEF_VEC_LEN,
    parameter int unsigned ACC_WIDTH      = acc_width(IN_WIDTH, VEC_LEN),
    parameter int unsigned OUT_PIPE_DEPTH = 0,
    localparam int unsigned IDX_WIDTH     = idx_width(VEC_LEN)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        inReady,
    input  logic signed [IN_WIDTH-1:0]  DP,
    output logic [IDX_WIDTH-1:0]        termIndex,
    output logic signed [ACC_WIDTH-1:0] SUM,
    output logic                        outReady,
    output logic                        earlyOutReady
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] dp_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic                        sum_vld;
    logic                        accept;
    logic                        last;
    logic                        pipe_pre_valid;

    assign dp_ext = ACC_WIDTH'(DP);

    // The first term of a vector overwrites, so a finished vector needs no flush cycle.
    always_comb begin
        accept   = enable && inReady && !clear;
        last     = accept && (termIndex == IDX_WIDTH'(VEC_LEN - 1));
        acc_next = ((termIndex == '0) ? '0 : acc) + dp_ext;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            termIndex <= '0;
            acc       <= '0;
            sum_q     <= '0;
            sum_vld   <= 1'b0;
        end else if (enable) begin
            if (clear) begin
                termIndex <= '0;
                acc       <= '0;
                sum_vld   <= 1'b0;
            end else begin
                sum_vld <= last;
                if (last) begin
                    sum_q     <= acc_next;
                    termIndex <= '0;
                    acc       <= '0;
                end else if (accept) begin
                    acc       <= acc_next;
                    termIndex <= termIndex + IDX_WIDTH'(1);
                end
            end
        end
    end

    valid_delay_line #(
        .WIDTH (ACC_WIDTH),
        .DEPTH (OUT_PIPE_DEPTH)
    ) u_out_pipe (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .in_data   (sum_q),
        .in_valid  (sum_vld),
        .out_data  (SUM),
        .out_valid (outReady),
        .pre_valid (pipe_pre_valid)
    );

    assign earlyOutReady = (OUT_PIPE_DEPTH == 0) ? last : pipe_pre_valid;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three shared-stimulus instances checked against a
// term-list/result-queue model of the accumulate-and-emit rules.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        reset, enable, clear, inReady;
    logic [19:0] DP;

    logic [1:0]  idx4, idx4p;
    logic [3:0]  idx16;
    logic [21:0] sum4, sum4p;
    logic [23:0] sum16;
    logic        ov4, ov16, ov4p, er4, er16, er4p;

    always #5 clk = ~clk;

    product_accumulator #(.IN_WIDTH(20), .VEC_LEN(4), .OUT_PIPE_DEPTH(0)) u4 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inReady(inReady), .DP(DP),
        .termIndex(idx4), .SUM(sum4), .outReady(ov4), .earlyOutReady(er4));
    product_accumulator #(.IN_WIDTH(20), .VEC_LEN(16), .OUT_PIPE_DEPTH(0)) u16 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inReady(inReady), .DP(DP),
        .termIndex(idx16), .SUM(sum16), .outReady(ov16), .earlyOutReady(er16));
    product_accumulator #(.IN_WIDTH(20), .VEC_LEN(4), .OUT_PIPE_DEPTH(2)) u4p (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inReady(inReady), .DP(DP),
        .termIndex(idx4p), .SUM(sum4p), .outReady(ov4p), .earlyOutReady(er4p));

    int     n_of [3] = '{4, 16, 4};
    int     d_of [3] = '{0, 0, 2};
    int     w_of [3] = '{22, 24, 22};

    int     cnt  [3];
    longint part [3];
    longint ecnt;
    logic   m_ov [3];
    longint m_sum[3];
    longint q_due[3][$];
    longint q_val[3][$];

    int     o_idx[3];
    longint o_sum[3];
    logic   o_ov [3];
    logic   o_er [3];
    logic   x_er [3];

    int passed, total;

    function automatic longint wrap(input longint v, input int w);
        return v & ((64'sd1 <<< w) - 64'sd1);
    endfunction

    task automatic model_reset();
        ecnt = 0;
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0; part[k] = 0; m_ov[k] = 1'b0; m_sum[k] = 0;
            q_due[k].delete(); q_val[k].delete();
        end
    endtask

    task automatic capture_regs();
        o_idx[0] = int'(idx4);  o_idx[1] = int'(idx16); o_idx[2] = int'(idx4p);
        o_sum[0] = longint'(sum4); o_sum[1] = longint'(sum16); o_sum[2] = longint'(sum4p);
        o_ov[0]  = ov4;  o_ov[1]  = ov16; o_ov[2]  = ov4p;
    endtask

    // One clock: drive at negedge, sample early strobes, update model at posedge, sample registers.
    task automatic step(input logic en, input logic ir, input logic clr, input logic [19:0] dp);
        @(negedge clk);
        enable = en; inReady = ir; clear = clr; DP = dp;
        #1;
        o_er[0] = er4; o_er[1] = er16; o_er[2] = er4p;
        for (int k = 0; k < 3; k++) begin
            if (d_of[k] == 0)
                x_er[k] = en && ir && !clr && (cnt[k] == n_of[k] - 1);
            else
                x_er[k] = (q_due[k].size() > 0) && (q_due[k][0] == ecnt + 1);
        end
        @(posedge clk);
        if (en) begin
            ecnt++;
            for (int k = 0; k < 3; k++) begin
                if (clr) begin
                    cnt[k] = 0; part[k] = 0; m_ov[k] = 1'b0;
                    q_due[k].delete(); q_val[k].delete();
                end else begin
                    if (ir) begin
                        part[k] += longint'($signed(dp));
                        if (cnt[k] == n_of[k] - 1) begin
                            q_due[k].push_back(ecnt + d_of[k]);
                            q_val[k].push_back(wrap(part[k], w_of[k]));
                            cnt[k] = 0; part[k] = 0;
                        end else begin
                            cnt[k]++;
                        end
                    end
                    if (q_due[k].size() > 0 && q_due[k][0] == ecnt) begin
                        m_ov[k]  = 1'b1;
                        m_sum[k] = q_val[k].pop_front();
                        void'(q_due[k].pop_front());
                    end else begin
                        m_ov[k] = 1'b0;
                    end
                end
            end
        end
        #1;
        capture_regs();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; clear = 1'b0; inReady = 1'b1; DP = 20'd7;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        capture_regs();
        o_er[0] = er4; o_er[1] = er16; o_er[2] = er4p;
        for (int k = 0; k < 3; k++) begin
            total++; if (o_idx[k] !== 0) $display("FAIL reset_idx[%0d]: got %0d want 0", k, o_idx[k]); else passed++;
            total++; if (o_sum[k] !== 0) $display("FAIL reset_sum[%0d]: got %0d want 0", k, o_sum[k]); else passed++;
            total++; if (o_ov[k] !== 1'b0) $display("FAIL reset_ov[%0d]: got %b want 0", k, o_ov[k]); else passed++;
        end
        total++; if (o_er[2] !== 1'b0) $display("FAIL reset_early_pipe: got %b want 0", o_er[2]); else passed++;
        @(negedge clk);
        reset = 1'b1; inReady = 1'b0;
    endtask

    task automatic test_basic();
        step(1, 0, 1, 0);
        step(1, 1, 0, 20'd1); step(1, 1, 0, 20'd2); step(1, 1, 0, 20'd3);
        total++; if (o_er[0] !== 1'b0) $display("FAIL basic_early_term3: got %b want 0", o_er[0]); else passed++;
        step(1, 1, 0, 20'd4);
        total++; if (o_er[0] !== 1'b1) $display("FAIL basic_early_term4: got %b want 1", o_er[0]); else passed++;
        total++; if (o_ov[0] !== 1'b1) $display("FAIL basic_ov: got %b want 1", o_ov[0]); else passed++;
        total++; if (o_sum[0] !== 10) $display("FAIL basic_sum: got %0d want 10", o_sum[0]); else passed++;
        step(1, 0, 0, 0);
        total++; if (o_ov[0] !== 1'b0) $display("FAIL basic_ov_one_cycle: got %b want 0", o_ov[0]); else passed++;
        total++; if (o_sum[0] !== 10) $display("FAIL basic_sum_hold: got %0d want 10", o_sum[0]); else passed++;
    endtask

    task automatic test_extremes();
        step(1, 0, 1, 0);
        repeat (16) step(1, 1, 0, 20'h80000);
        total++; if (o_ov[1] !== 1'b1) $display("FAIL ext_min_ov: got %b want 1", o_ov[1]); else passed++;
        total++; if (o_sum[1] !== 64'h800000) $display("FAIL ext_min_sum: got %h want 800000", o_sum[1]); else passed++;
        repeat (16) step(1, 1, 0, 20'h7FFFF);
        total++; if (o_ov[1] !== 1'b1) $display("FAIL ext_max_ov: got %b want 1", o_ov[1]); else passed++;
        total++; if (o_sum[1] !== 8388592) $display("FAIL ext_max_sum: got %0d want 8388592", o_sum[1]); else passed++;
    endtask

    task automatic test_gaps();
        step(1, 0, 1, 0);
        step(1, 1, 0, 20'd5); step(1, 0, 0, 0); step(1, 1, 0, 20'd6);
        step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 20'd7);
        repeat (3) begin
            step(0, 1, 0, 20'($urandom));
            total++; if (o_idx[0] !== 3) $display("FAIL gaps_idx_hold: got %0d want 3", o_idx[0]); else passed++;
        end
        step(1, 1, 0, 20'd8);
        total++; if (o_ov[0] !== 1'b1) $display("FAIL gaps_ov: got %b want 1", o_ov[0]); else passed++;
        total++; if (o_sum[0] !== 26) $display("FAIL gaps_sum: got %0d want 26", o_sum[0]); else passed++;
        step(0, 0, 0, 0);
        total++; if (o_ov[0] !== 1'b1) $display("FAIL gaps_ov_frozen: got %b want 1", o_ov[0]); else passed++;
        step(1, 0, 0, 0);
        total++; if (o_ov[0] !== 1'b0) $display("FAIL gaps_ov_drop: got %b want 0", o_ov[0]); else passed++;
    endtask

    task automatic test_back_to_back();
        step(1, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 0, 20'(i));
            total++;
            if (o_ov[0] !== ((i == 4) || (i == 8)))
                $display("FAIL b2b_ov[%0d]: got %b want %b", i, o_ov[0], ((i == 4) || (i == 8)));
            else passed++;
            if (i == 4) begin
                total++; if (o_sum[0] !== 10) $display("FAIL b2b_sum1: got %0d want 10", o_sum[0]); else passed++;
            end
            if (i == 8) begin
                total++; if (o_sum[0] !== 26) $display("FAIL b2b_sum2: got %0d want 26", o_sum[0]); else passed++;
            end
        end
    endtask

    task automatic test_clear();
        step(1, 0, 1, 0);
        step(1, 1, 0, 20'd9); step(1, 1, 0, 20'd9);
        step(1, 1, 1, 20'd9);
        total++; if (o_idx[0] !== 0) $display("FAIL clear_idx: got %0d want 0", o_idx[0]); else passed++;
        repeat (4) step(1, 1, 0, 20'd7);
        total++; if (o_ov[0] !== 1'b1) $display("FAIL clear_ov: got %b want 1", o_ov[0]); else passed++;
        total++; if (o_sum[0] !== 28) $display("FAIL clear_sum: got %0d want 28", o_sum[0]); else passed++;
    endtask

    task automatic test_async_reset();
        step(1, 1, 0, 20'd3); step(1, 1, 0, 20'd3);
        total++; if (o_idx[0] !== 2) $display("FAIL areset_pre_idx: got %0d want 2", o_idx[0]); else passed++;
        @(negedge clk);
        enable = 1'b1; inReady = 1'b0; clear = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        total++; if (idx4 !== 2'd0) $display("FAIL areset_idx: got %0d want 0", idx4); else passed++;
        total++; if (sum4 !== 22'd0) $display("FAIL areset_sum: got %0d want 0", sum4); else passed++;
        total++; if (ov4 !== 1'b0) $display("FAIL areset_ov: got %b want 0", ov4); else passed++;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step(1, 1, 0, 20'd1);
        total++; if (o_ov[0] !== 1'b1) $display("FAIL areset_after_ov: got %b want 1", o_ov[0]); else passed++;
        total++; if (o_sum[0] !== 4) $display("FAIL areset_after_sum: got %0d want 4", o_sum[0]); else passed++;
    endtask

    task automatic test_pipe();
        step(1, 0, 1, 0);
        step(1, 1, 0, 20'd1); step(1, 1, 0, 20'd2); step(1, 1, 0, 20'd3);
        step(1, 1, 0, 20'd4);
        total++; if (o_ov[2] !== 1'b0) $display("FAIL pipe_ov_c0: got %b want 0", o_ov[2]); else passed++;
        step(1, 0, 0, 0);
        total++; if (o_er[2] !== 1'b0) $display("FAIL pipe_early_c1: got %b want 0", o_er[2]); else passed++;
        total++; if (o_ov[2] !== 1'b0) $display("FAIL pipe_ov_c1: got %b want 0", o_ov[2]); else passed++;
        step(1, 0, 0, 0);
        total++; if (o_er[2] !== 1'b1) $display("FAIL pipe_early_c2: got %b want 1", o_er[2]); else passed++;
        total++; if (o_ov[2] !== 1'b1) $display("FAIL pipe_ov_c3: got %b want 1", o_ov[2]); else passed++;
        total++; if (o_sum[2] !== 10) $display("FAIL pipe_sum: got %0d want 10", o_sum[2]); else passed++;
        step(1, 0, 0, 0);
        total++; if (o_er[2] !== 1'b0) $display("FAIL pipe_early_c3: got %b want 0", o_er[2]); else passed++;
        total++; if (o_ov[2] !== 1'b0) $display("FAIL pipe_ov_c4: got %b want 0", o_ov[2]); else passed++;
    endtask

    task automatic test_random();
        step(1, 0, 1, 0);
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0, 20'($urandom));
            for (int k = 0; k < 3; k++) begin
                total++; if (o_idx[k] !== cnt[k]) $display("FAIL rnd_idx[%0d] c%0d: got %0d want %0d", k, c, o_idx[k], cnt[k]); else passed++;
                total++; if (o_sum[k] !== m_sum[k]) $display("FAIL rnd_sum[%0d] c%0d: got %0d want %0d", k, c, o_sum[k], m_sum[k]); else passed++;
                total++; if (o_ov[k] !== m_ov[k]) $display("FAIL rnd_ov[%0d] c%0d: got %b want %b", k, c, o_ov[k], m_ov[k]); else passed++;
                total++; if (o_er[k] !== x_er[k]) $display("FAIL rnd_early[%0d] c%0d: got %b want %b", k, c, o_er[k], x_er[k]); else passed++;
            end
        end
    endtask

    initial begin
        passed = 0; total = 0;
        reset = 1'b0; enable = 1'b0; clear = 1'b0; inReady = 1'b0; DP = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_gaps();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_pipe();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
